// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: frame-coherent shadow of the inputs, prescaled scan.
// Define SEVSEG_HEX_EN to decode codes 10..15 as A,b,C,d,E,F; otherwise those codes blank.
module seven_seg_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    localparam int unsigned IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] nums,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode_active,
    output logic [IDXW-1:0]         digit_sel,
    output logic                    frame_tick
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRES_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_DIGITS - 1);
    localparam logic [6:0]      SEG_OFF   = 7'h7F;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] seg;
        unique case (code)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
`ifdef SEVSEG_HEX_EN
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
`else
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: seg = SEG_OFF;
`endif
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]           pres_q, pres_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] nums_sh_q, nums_sh_d;
    logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [IDXW-1:0]       sel_q, sel_d;
    logic                  tick_q, tick_d;

    logic [3:0] cur_nib;
    logic       cur_blank;
    logic       cur_dp;

    // Scan sequencing; the shadow only reloads while disabled or on frame wrap.
    always_comb begin
        pres_d     = pres_q;
        idx_d      = idx_q;
        nums_sh_d  = nums_sh_q;
        blank_sh_d = blank_sh_q;
        dp_sh_d    = dp_sh_q;
        tick_d     = 1'b0;
        if (!en) begin
            pres_d     = '0;
            idx_d      = '0;
            nums_sh_d  = nums;
            blank_sh_d = blank_mask;
            dp_sh_d    = dp_in;
        end else if (pres_q == PRES_LAST) begin
            pres_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d      = '0;
                nums_sh_d  = nums;
                blank_sh_d = blank_mask;
                dp_sh_d    = dp_in;
                tick_d     = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            pres_d = pres_q + 1'b1;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        anode_d   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_nib    = nums_sh_q[4*i +: 4];
                cur_blank  = blank_sh_q[i];
                cur_dp     = dp_sh_q[i];
                anode_d[i] = 1'b1;
            end
        end
        sel_d = idx_q;
        seg_d = cur_blank ? SEG_OFF : decode(cur_nib);
        dp_d  = cur_blank ? 1'b1 : ~cur_dp;
        if (!en) begin
            anode_d = '0;
            sel_d   = '0;
            seg_d   = SEG_OFF;
            dp_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pres_q     <= '0;
            idx_q      <= '0;
            nums_sh_q  <= '0;
            blank_sh_q <= '0;
            dp_sh_q    <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
            anode_q    <= '0;
            sel_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            pres_q     <= pres_d;
            idx_q      <= idx_d;
            nums_sh_q  <= nums_sh_d;
            blank_sh_q <= blank_sh_d;
            dp_sh_q    <= dp_sh_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            anode_q    <= anode_d;
            sel_q      <= sel_d;
            tick_q     <= tick_d;
        end
    end

    assign segments     = seg_q;
    assign dp           = dp_q;
    assign anode_active = anode_q;
    assign digit_sel    = sel_q;
    assign frame_tick   = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (4 digits, 3-cycle refresh) plus a 1-digit/1-cycle corner.
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] nums;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_in;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anode_active;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    logic [6:0]  segments1;
    logic        dp1;
    logic [0:0]  anode1;
    logic [0:0]  sel1;
    logic        tick1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] exp_v;
    logic [14:0] act_v;

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(3)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .nums         (nums),
        .blank_mask   (blank_mask),
        .dp_in        (dp_in),
        .segments     (segments),
        .dp           (dp),
        .anode_active (anode_active),
        .digit_sel    (digit_sel),
        .frame_tick   (frame_tick)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .nums         (nums[3:0]),
        .blank_mask   (blank_mask[0]),
        .dp_in        (dp_in[0]),
        .segments     (segments1),
        .dp           (dp1),
        .anode_active (anode1),
        .digit_sel    (sel1),
        .frame_tick   (tick1)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
`ifdef SEVSEG_HEX_EN
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            4'hF: return 7'b0001110;
`endif
            default: return 7'h7F;
        endcase
    endfunction

    // {anode, digit_sel, segments, dp, frame_tick} while digit d of (v,bm,dpm) is shown
    function automatic logic [14:0] lit(input int d, input logic [15:0] v, input logic [3:0] bm,
                                        input logic [3:0] dpm, input logic tk);
        logic [3:0] nib;
        logic [3:0] an;
        logic [1:0] di;
        nib = v[4*d +: 4];
        an  = 4'b0001 << d;
        di  = 2'(d);
        return {an, di, bm[d] ? 7'h7F : seg_of(nib), bm[d] ? 1'b1 : ~dpm[d], tk};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_and_enable();
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; nums = 16'h1234; blank_mask = 4'b0000; dp_in = 4'b0000;
        #2;
        for (int i = 0; i < 3; i++) begin
            act_v = {anode_active, digit_sel, segments, dp, frame_tick};
            exp_v = {4'b0000, 2'd0, 7'h7F, 1'b1, 1'b0};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", i, act_v, exp_v);
            end
            tick();
        end
    endtask

    // First frame after reset shows the zeroed shadow; 1234 appears after the first wrap.
    task automatic test_scan();
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            act_v = {anode_active, digit_sel, segments, dp, frame_tick};
            exp_v = lit(((k - 1) / 3) % 4, (k <= 12) ? 16'h0000 : 16'h1234, 4'b0000, 4'b0000,
                        (k % 12) == 0);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL scan[%0d]: got %h expected %h", k, act_v, exp_v);
            end
        end
    endtask

    task automatic test_coherence();
        nums = 16'h1234;
        load_and_enable();
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 5) nums = 16'h5678;
            act_v = {anode_active, digit_sel, segments, dp, frame_tick};
            exp_v = lit(((k - 1) / 3) % 4, (k <= 12) ? 16'h1234 : 16'h5678, 4'b0000, 4'b0000,
                        (k % 12) == 0);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL coherence[%0d]: got %h expected %h", k, act_v, exp_v);
            end
        end
    endtask

    task automatic test_blank_dp();
        nums = 16'h1234; blank_mask = 4'b1000; dp_in = 4'b1001;
        load_and_enable();
        for (int k = 1; k <= 12; k++) begin
            tick();
            act_v = {anode_active, digit_sel, segments, dp, frame_tick};
            exp_v = lit((k - 1) / 3, 16'h1234, 4'b1000, 4'b1001, k == 12);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL blank_dp[%0d]: got %h expected %h", k, act_v, exp_v);
            end
        end
        blank_mask = 4'b0000; dp_in = 4'b0000;
    endtask

    task automatic test_hex();
        nums = 16'hCFA0;
        load_and_enable();
        for (int k = 1; k <= 12; k++) begin
            tick();
            act_v = {anode_active, digit_sel, segments, dp, frame_tick};
            exp_v = lit((k - 1) / 3, 16'hCFA0, 4'b0000, 4'b0000, k == 12);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL hex[%0d]: got %h expected %h", k, act_v, exp_v);
            end
        end
    endtask

    task automatic test_en_drop();
        nums = 16'h1234;
        load_and_enable();
        for (int k = 1; k <= 7; k++) tick();
        n_checks++;
        if (anode_active !== 4'b0100) begin
            n_fail++;
            $display("FAIL en_drop_pre: anode %b expected 0100", anode_active);
        end
        en = 1'b0;
        tick();
        act_v = {anode_active, digit_sel, segments, dp, frame_tick};
        exp_v = {4'b0000, 2'd0, 7'h7F, 1'b1, 1'b0};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL en_drop_blank: got %h expected %h", act_v, exp_v);
        end
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            act_v = {anode_active, digit_sel, segments, dp, frame_tick};
            exp_v = lit((k - 1) / 3, 16'h1234, 4'b0000, 4'b0000, 1'b0);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL en_restart[%0d]: got %h expected %h", k, act_v, exp_v);
            end
        end
    endtask

    // Single digit, REFRESH_DIV=1: every enabled cycle is a wrap.
    task automatic test_single_digit();
        nums = 16'h0007; dp_in = 4'b0001;
        load_and_enable();
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if ({anode1, sel1, segments1, dp1, tick1} !== {1'b1, 1'b0, 7'b1111000, 1'b0, 1'b1})
            begin
                n_fail++;
                $display("FAIL single[%0d]: got %b_%b_%b_%b_%b expected 1_0_1111000_0_1",
                         k, anode1, sel1, segments1, dp1, tick1);
            end
        end
        dp_in = 4'b0000;
    endtask

    task automatic test_async_reset();
        nums = 16'h1234;
        load_and_enable();
        for (int k = 1; k <= 4; k++) tick();
        #2 rst = 1'b1;
        #1;
        act_v = {anode_active, digit_sel, segments, dp, frame_tick};
        exp_v = {4'b0000, 2'd0, 7'h7F, 1'b1, 1'b0};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", act_v, exp_v);
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_coherence();
        test_blank_dp();
        test_hex();
        test_en_drop();
        test_single_digit();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
